// File: rtl/mem_ctrl_pkg.sv
// Purpose: shared types and constants for the data memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Value returned to the core when the memory never answers.
    localparam logic [31:0] TIMEOUT_FILL    = 32'hDEAD_BEEF;
    // Byte-offset bits that must be zero for a word access.
    localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return |(byte_off & WORD_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Purpose: 8-bit wait counter bounding how long a memory access may stay outstanding.
// Latency: count updates one cycle after enable; tc_o is combinational from the count.
// Backpressure: none; clr_i has priority over en_i.
// Ports: clk, rst_n, clr_i (zero the count), en_i (advance), tc_o (count == TERMINAL).
module mem_wait_counter #(
    parameter logic [7:0] TERMINAL = 8'd63
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && !tc_o) begin
            // Hold at terminal count; the owner leaves the wait state there anyway.
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TERMINAL);

endmodule

// File: rtl/data_mem_controller.sv
// Purpose: bridges single-cycle core load/store strobes to a req/ack data memory, stalling the core meanwhile.
// Latency: aligned access 3+ cycles (IDLE->BUSY->DONE), misaligned 2 cycles, timeout TIMEOUT_CYCLES+2 cycles.
// Backpressure: Stall holds the core from the request cycle until DONE; mem_req is held until mem_ack or timeout.
// Ports: core side MemRead/MemWrite/Addr/WriteData in, ReadData/Stall/MemErr out;
//        memory side mem_req/mem_we/mem_addr/mem_wdata out, mem_ack/mem_rdata in.
module data_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Stall,
    output logic                  MemErr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                state_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  mem_err_q;

    logic access_req;
    logic wait_tc;

    assign access_req = MemRead || MemWrite;

    // Count only cycles spent waiting without an ack; any other state rearms it.
    mem_wait_counter #(
        .TERMINAL (8'(TIMEOUT_CYCLES - 1))
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q != BUSY),
        .en_i  ((state_q == BUSY) && !mem_ack),
        .tc_o  (wait_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            read_data_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            // Error flag is a pulse: only the transition into DONE can raise it.
            mem_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access_req) begin
                        if (is_misaligned(Addr[1:0])) begin
                            mem_err_q   <= 1'b1;
                            read_data_q <= '0;
                            state_q     <= DONE;
                        end else begin
                            // Both strobes high resolves to a write via MemWrite.
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= MemWrite;
                            mem_addr_q  <= {Addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata_q <= WriteData;
                            state_q     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            read_data_q <= mem_rdata;
                        end
                        state_q <= DONE;
                    end else if (wait_tc) begin
                        mem_req_q   <= 1'b0;
                        mem_err_q   <= 1'b1;
                        read_data_q <= DATA_WIDTH'(TIMEOUT_FILL);
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Combinational so the core freezes in the very cycle the request appears.
    assign Stall     = ((state_q == IDLE) && access_req) || (state_q == BUSY);
    assign ReadData  = read_data_q;
    assign MemErr    = mem_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
